// File: rtl/cnn_result_drain_pkg.sv
// Shared types and constants for the CNN result drain.
//   drain_state_e : job FSM encoding (IDLE / RUN / DRAIN)
//   KEEP_ALL      : all-lanes keep mask, widest supported PACK
//   keep_of()     : thermometer keep mask for n filled lanes
package cnn_result_drain_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} drain_state_e;

  localparam int MAX_PACK = 32;
  localparam logic [MAX_PACK-1:0] KEEP_ALL = '1;

  function automatic logic [MAX_PACK-1:0] keep_of(input int unsigned n);
    if (n >= MAX_PACK) return KEEP_ALL;
    return KEEP_ALL >> (MAX_PACK - n);
  endfunction

endpackage

// File: rtl/cnn_result_drain_if.sv
// Signal bundle between the drain and its environment: job control,
// result-buffer read port and the packed output stream.
//   master : the drain (drives read enable, output stream, status)
//   slave  : buffer / host side
interface cnn_result_drain_if #(
  parameter int RESULT_BUFFER_WIDTH = 8,
  parameter int PACK                = 4,
  parameter int COUNT_WIDTH         = 16
);
  logic                                start;
  logic [COUNT_WIDTH-1:0]              num_results;
  logic                                result_buffer_empty;
  logic                                result_buffer_read_enable;
  logic                                result_buffer_valid;
  logic [RESULT_BUFFER_WIDTH-1:0]      result_buffer_out;
  logic [PACK*RESULT_BUFFER_WIDTH-1:0] out_data;
  logic [PACK-1:0]                     out_keep;
  logic                                out_last;
  logic                                out_valid;
  logic                                out_ready;
  logic                                busy;
  logic                                done;
  logic                                error;

  modport master (
    input  start, num_results, result_buffer_empty, result_buffer_valid,
           result_buffer_out, out_ready,
    output result_buffer_read_enable, out_data, out_keep, out_last,
           out_valid, busy, done, error
  );

  modport slave (
    output start, num_results, result_buffer_empty, result_buffer_valid,
           result_buffer_out, out_ready,
    input  result_buffer_read_enable, out_data, out_keep, out_last,
           out_valid, busy, done, error
  );
endinterface

// File: rtl/cnn_result_drain_result_packer.sv
// Packs accepted result beats into PACK-lane words and holds the output
// register of the valid/ready stream.
//   beat_i/data_i/final_i : accepted beat, its data, and "last of job"
//   out_*                 : registered output stream
//   pack_full_o           : a complete word is parked waiting for the slot
//   last_lane_o           : next beat lands in lane PACK-1
module result_packer
  import cnn_result_drain_pkg::*;
#(
  parameter int W    = 8,
  parameter int PACK = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                beat_i,
  input  logic [W-1:0]        data_i,
  input  logic                final_i,
  input  logic                out_ready_i,
  output logic [PACK*W-1:0]   out_data_o,
  output logic [PACK-1:0]     out_keep_o,
  output logic                out_last_o,
  output logic                out_valid_o,
  output logic                pack_full_o,
  output logic                last_lane_o
);
  localparam int LW = $clog2(PACK + 1);

  logic [PACK-1:0][W-1:0] lane_q, lane_d, word_nx, out_data_q;
  logic [LW-1:0]          lanes_q, cnt_nx;
  logic [MAX_PACK-1:0]    keep_full;
  logic [PACK-1:0]        keep_nx, out_keep_q;
  logic                   pack_full_q, held_last_q, out_last_q, out_valid_q;
  logic                   complete, load, last_nx;

  always_comb begin
    lane_d = lane_q;
    for (int i = 0; i < PACK; i++)
      if (beat_i && LW'(i) == lanes_q) lane_d[i] = data_i;
    cnt_nx    = lanes_q + LW'(beat_i);
    keep_full = keep_of(32'(cnt_nx));
    keep_nx   = keep_full[PACK-1:0];
    // stale lanes from earlier words are masked off so unfilled lanes read 0
    for (int i = 0; i < PACK; i++)
      word_nx[i] = keep_nx[i] ? lane_d[i] : '0;
    complete = beat_i && (lanes_q == LW'(PACK - 1) || final_i);
    // a parked word only exists while out_valid is high, so it moves on handshake
    load     = (!out_valid_q || out_ready_i) && (complete || pack_full_q);
    last_nx  = beat_i ? final_i : held_last_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q      <= '0;
      lanes_q     <= '0;
      pack_full_q <= 1'b0;
      held_last_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      if (load) begin
        out_data_q  <= word_nx;
        out_keep_q  <= keep_nx;
        out_last_q  <= last_nx;
        out_valid_q <= 1'b1;
        lanes_q     <= '0;
        pack_full_q <= 1'b0;
      end else begin
        if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
        lanes_q <= cnt_nx;
        if (complete) begin
          pack_full_q <= 1'b1;
          held_last_q <= final_i;
        end
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign out_last_o  = out_last_q;
  assign out_valid_o = out_valid_q;
  assign pack_full_o = pack_full_q;
  assign last_lane_o = (lanes_q == LW'(PACK - 1));
endmodule

// File: rtl/cnn_result_drain.sv
// Read-side master for the result buffer. Issues one read per cycle (at
// most one outstanding) until num_results entries are requested, packs
// them PACK per word and streams words out with keep/last flags.
//   clk, reset_n : clock, async active-low reset
//   bus          : control, buffer read port and output stream (master)
module cnn_result_drain
  import cnn_result_drain_pkg::*;
#(
  parameter int RESULT_BUFFER_WIDTH = 8,
  parameter int PACK                = 4,
  parameter int COUNT_WIDTH         = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  cnn_result_drain_if.master bus
);
  localparam int CW = COUNT_WIDTH;

  drain_state_e  state_q, state_d;
  logic [CW-1:0] total_q, issued_q, received_q;
  logic          inflight_q, busy_q, done_q, error_q;
  logic          start_ok, beat, final_beat, complete_now, rd_en, drain_end;
  logic          pack_full, last_lane;

  assign start_ok     = bus.start && !busy_q && state_q == ST_IDLE;
  assign beat         = bus.result_buffer_valid && inflight_q;  // spurious beats dropped
  assign final_beat   = (received_q + CW'(1)) == total_q;
  assign complete_now = bus.result_buffer_valid && (last_lane || final_beat);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok && bus.num_results != '0) state_d = ST_RUN;
      ST_RUN:   if (issued_q == total_q) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Never read into a word that would have nowhere to go next edge.
  always_comb begin
    rd_en = (state_q == ST_RUN) && !bus.result_buffer_empty &&
            (issued_q < total_q) && !pack_full &&
            (!inflight_q || bus.result_buffer_valid) &&
            !(complete_now && bus.out_valid && !bus.out_ready);
    drain_end = (state_q == ST_DRAIN) && bus.out_valid && bus.out_ready && bus.out_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      total_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        total_q    <= bus.num_results;
        issued_q   <= '0;
        received_q <= '0;
        error_q    <= 1'b0;
        busy_q     <= 1'b1;
        done_q     <= (bus.num_results == '0);
      end else begin
        issued_q   <= issued_q + CW'(rd_en);
        received_q <= received_q + CW'(beat);
        done_q     <= drain_end;
        if (done_q) busy_q <= 1'b0;
      end
      if (rd_en)                        inflight_q <= 1'b1;
      else if (bus.result_buffer_valid) inflight_q <= 1'b0;
      if (bus.result_buffer_valid && !inflight_q) error_q <= 1'b1;
    end
  end

  result_packer #(.W(RESULT_BUFFER_WIDTH), .PACK(PACK)) u_packer (
    .clk         (clk),
    .reset_n     (reset_n),
    .beat_i      (beat),
    .data_i      (bus.result_buffer_out),
    .final_i     (final_beat),
    .out_ready_i (bus.out_ready),
    .out_data_o  (bus.out_data),
    .out_keep_o  (bus.out_keep),
    .out_last_o  (bus.out_last),
    .out_valid_o (bus.out_valid),
    .pack_full_o (pack_full),
    .last_lane_o (last_lane)
  );

  assign bus.result_buffer_read_enable = rd_en;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.error = error_q;
endmodule
